atm_txn_engine: RTL and testbench

Transaction engine for the ATM datapath. It sits between the pushbutton debouncers and the BCD display path. It turns debounced deposit/withdraw button levels plus the bill switch setting into committed balance updates. It drives the 8-bit balance to the binary-to-BCD display path and the error LEDs. Each request is handled by a small FSM that validates the bill and checks overflow/underflow. After an error, the error flags hold for a fixed period before the engine accepts the next request.

---
 rtl/atm_txn_engine.sv | 171 +++++++++++++++++
 tb/tb_atm_txn_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_txn_engine.sv
// ATM transaction engine: turns debounced deposit/withdraw button edges into validated balance updates.
// Optional feature macro ATM_SATURATE_EN: out-of-range transactions commit with a clamped balance.
module atm_txn_engine #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dep_btn,
    input  logic       wdr_btn,
    input  logic [5:0] sw,
    output logic [7:0] balance,
    output logic [7:0] bill_value,
    output logic       txn_done,
    output logic       busy,
    output logic       err_bill,
    output logic       err_over,
    output logic       err_under
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DECODE, CHECK, COMMIT, HOLD} state_t;

    state_t state, state_next;

    logic             dep_cur, dep_prev, wdr_cur, wdr_prev;
    logic             dep_edge, wdr_edge;
    logic             op_wdr;
    logic [7:0]       bill_reg;
    logic [CNT_W-1:0] hold_cnt;
    logic [8:0]       dep_sum;
    logic [7:0]       commit_value;
    logic             err_any;
    logic             start_dep, start_wdr, latch_bill;
    logic             set_bill, set_over, set_under, do_commit, hold_done;

    assign dep_edge = dep_cur & ~dep_prev;
    assign wdr_edge = wdr_cur & ~wdr_prev;
    assign err_any  = err_bill | err_over | err_under;
    assign busy     = (state != IDLE);
    assign dep_sum  = {1'b0, balance} + {1'b0, bill_reg};

    always_comb begin
        bill_value = 8'd0;
        case (sw)
            6'b000001: bill_value = 8'd1;
            6'b000010: bill_value = 8'd5;
            6'b000100: bill_value = 8'd10;
            6'b001000: bill_value = 8'd20;
            6'b010000: bill_value = 8'd50;
            6'b100000: bill_value = 8'd100;
            default:   bill_value = 8'd0;
        endcase
    end

    // Clamping only matters when an out-of-range transaction is allowed to reach COMMIT.
    always_comb begin
        commit_value = 8'd0;
        if (!op_wdr)
            commit_value = dep_sum[8] ? 8'hFF : dep_sum[7:0];
        else
            commit_value = (bill_reg > balance) ? 8'h00 : balance - bill_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_dep  = 1'b0;
        start_wdr  = 1'b0;
        latch_bill = 1'b0;
        set_bill   = 1'b0;
        set_over   = 1'b0;
        set_under  = 1'b0;
        do_commit  = 1'b0;
        hold_done  = 1'b0;
        case (state)
            IDLE: begin
                if (dep_edge && !wdr_edge) begin
                    start_dep  = 1'b1;
                    state_next = DECODE;
                end else if (wdr_edge && !dep_edge) begin
                    start_wdr  = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                latch_bill = 1'b1;
                if (bill_value == 8'd0) begin
                    set_bill   = 1'b1;
                    state_next = HOLD;
                end else begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = COMMIT;
                if (!op_wdr && dep_sum[8]) begin
                    set_over = 1'b1;
`ifdef ATM_SATURATE_EN
                    state_next = COMMIT;
`else
                    state_next = HOLD;
`endif
                end else if (op_wdr && (bill_reg > balance)) begin
                    set_under = 1'b1;
`ifdef ATM_SATURATE_EN
                    state_next = COMMIT;
`else
                    state_next = HOLD;
`endif
                end
            end
            COMMIT: begin
                do_commit  = 1'b1;
                state_next = err_any ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The hold counter runs whenever a flag is up, so a flag raised in CHECK ahead of COMMIT still lasts HOLD_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dep_cur   <= 1'b0;
            dep_prev  <= 1'b0;
            wdr_cur   <= 1'b0;
            wdr_prev  <= 1'b0;
            op_wdr    <= 1'b0;
            bill_reg  <= 8'd0;
            balance   <= 8'd0;
            txn_done  <= 1'b0;
            err_bill  <= 1'b0;
            err_over  <= 1'b0;
            err_under <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            dep_cur  <= dep_btn;
            dep_prev <= dep_cur;
            wdr_cur  <= wdr_btn;
            wdr_prev <= wdr_cur;
            txn_done <= do_commit;
            if (start_dep) op_wdr <= 1'b0;
            if (start_wdr) op_wdr <= 1'b1;
            if (latch_bill) bill_reg <= bill_value;
            if (do_commit) balance <= commit_value;
            if (hold_done) begin
                err_bill  <= 1'b0;
                err_over  <= 1'b0;
                err_under <= 1'b0;
                hold_cnt  <= '0;
            end else begin
                if (set_bill)  err_bill  <= 1'b1;
                if (set_over)  err_over  <= 1'b1;
                if (set_under) err_under <= 1'b1;
                if (err_any)   hold_cnt  <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_atm_txn_engine.sv
// Self-checking bench for atm_txn_engine: directed scenarios plus randomized transactions
// checked against an arithmetic model of the account (balance, bill table, error rules).
module tb_atm_txn_engine;

    localparam int H = 8;
`ifdef ATM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       dep_btn;
    logic       wdr_btn;
    logic [5:0] sw;
    logic [7:0] balance;
    logic [7:0] bill_value;
    logic       txn_done;
    logic       busy;
    logic       err_bill;
    logic       err_over;
    logic       err_under;

    int n_compared;
    int n_mismatched;
    int model_bal;
    int bill_table[6] = '{1, 5, 10, 20, 50, 100};

    atm_txn_engine #(.HOLD_CYCLES(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .dep_btn   (dep_btn),
        .wdr_btn   (wdr_btn),
        .sw        (sw),
        .balance   (balance),
        .bill_value(bill_value),
        .txn_done  (txn_done),
        .busy      (busy),
        .err_bill  (err_bill),
        .err_over  (err_over),
        .err_under (err_under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int bill_of(input logic [5:0] s);
        if ($countones(s) != 1) return 0;
        for (int i = 0; i < 6; i++)
            if (s[i]) return bill_table[i];
        return 0;
    endfunction

    // kind: 0 = commit, 1 = bad bill, 2 = overflow, 3 = underflow
    function automatic void model_outcome(input bit is_wdr, input logic [5:0] s, input int bal,
                                          output int kind, output int exp_bal, output bit commits);
        int bill;
        bill    = bill_of(s);
        kind    = 0;
        exp_bal = bal;
        if (bill == 0) begin
            kind = 1;
        end else if (!is_wdr) begin
            if (bal + bill > 255) begin
                kind    = 2;
                exp_bal = SAT ? 255 : bal;
            end else begin
                exp_bal = bal + bill;
            end
        end else begin
            if (bill > bal) begin
                kind    = 3;
                exp_bal = SAT ? 0 : bal;
            end else begin
                exp_bal = bal - bill;
            end
        end
        commits = (kind == 0) || (SAT && kind >= 2);
    endfunction

    task automatic applyStimulus(input bit is_wdr, input logic [5:0] sw_val, input bit poke);
        int  kind, exp_bal, rise, last;
        bit  commits;
        logic flag;
        model_outcome(is_wdr, sw_val, model_bal, kind, exp_bal, commits);
        rise = (kind == 1) ? 2 : 3;
        last = (kind == 0) ? 5 : rise + H;
        @(negedge clk);
        sw = sw_val;
        #1;
        checkOutput("bill_value", 32'(bill_value), 32'(bill_of(sw_val)));
        @(negedge clk);
        if (is_wdr) wdr_btn = 1'b1;
        else        dep_btn = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            flag = (kind == 1) ? err_bill : (kind == 2) ? err_over : err_under;
            if (k == 1) checkOutput("busy_e1", 32'(busy), 32'd1);
            if (k == 2) begin
                checkOutput("err_bill_e2", 32'(err_bill), 32'(kind == 1));
                dep_btn = 1'b0;
                wdr_btn = 1'b0;
                sw = 6'($urandom);
            end
            if (k == 3) begin
                checkOutput("err_over_e3", 32'(err_over), 32'(kind == 2));
                checkOutput("err_under_e3", 32'(err_under), 32'(kind == 3));
                checkOutput("balance_e3", 32'(balance), 32'(model_bal));
                checkOutput("txn_done_e3", 32'(txn_done), 32'd0);
            end
            if (k == 4) begin
                checkOutput("txn_done_e4", 32'(txn_done), 32'(commits));
                checkOutput("balance_e4", 32'(balance), 32'(exp_bal));
                checkOutput("busy_e4", 32'(busy), 32'(kind != 0));
            end
            if (k == 5) checkOutput("txn_done_e5", 32'(txn_done), 32'd0);
            if (kind != 0 && poke && k == rise + 2) dep_btn = 1'b1;
            if (kind != 0 && poke && k == rise + 3) dep_btn = 1'b0;
            if (kind != 0 && k == rise + H - 1) begin
                checkOutput("flag_held", 32'(flag), 32'd1);
                checkOutput("busy_held", 32'(busy), 32'd1);
            end
            if (kind != 0 && k == rise + H) begin
                checkOutput("flag_cleared", 32'(flag), 32'd0);
                checkOutput("busy_after_hold", 32'(busy), 32'd0);
                checkOutput("balance_after_hold", 32'(balance), 32'(exp_bal));
            end
        end
        model_bal = exp_bal;
        if (poke && kind != 0) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                checkOutput("poke_ignored_busy", 32'(busy), 32'd0);
            end
            checkOutput("poke_ignored_balance", 32'(balance), 32'(model_bal));
        end
    endtask

    initial begin
        int kind, exp_bal, count;
        bit commits;
        logic [5:0] s;
        n_compared   = 0;
        n_mismatched = 0;
        model_bal    = 0;
        reset   = 1'b0;
        dep_btn = 1'b0;
        wdr_btn = 1'b0;
        sw      = 6'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_balance", 32'(balance), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_txn_done", 32'(txn_done), 32'd0);
        checkOutput("rst_errs", 32'({err_bill, err_over, err_under}), 32'd0);
        checkOutput("rst_bill_value", 32'(bill_value), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1'b0, 6'b000100, 1'b0);
        applyStimulus(1'b0, 6'b100000, 1'b0);
        applyStimulus(1'b0, 6'b100000, 1'b0);
        applyStimulus(1'b0, 6'b001000, 1'b0);
        applyStimulus(1'b0, 6'b001000, 1'b0);
        applyStimulus(1'b0, 6'b000010, 1'b0);
        applyStimulus(1'b0, 6'b000001, 1'b0);
        applyStimulus(1'b1, 6'b100000, 1'b0);
        applyStimulus(1'b1, 6'b100000, 1'b0);
        applyStimulus(1'b1, 6'b001000, 1'b0);
        applyStimulus(1'b1, 6'b000100, 1'b0);
        applyStimulus(1'b1, 6'b000010, 1'b0);
        applyStimulus(1'b1, 6'b010000, 1'b0);
        applyStimulus(1'b1, 6'b001000, 1'b0);
        applyStimulus(1'b0, 6'b000011, 1'b1);
        applyStimulus(1'b0, 6'b000000, 1'b1);

        // Simultaneous edges must be ignored entirely.
        @(negedge clk);
        sw = 6'b000100;
        dep_btn = 1'b1;
        wdr_btn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checkOutput("both_busy", 32'(busy), 32'd0);
            checkOutput("both_flags", 32'({err_bill, err_over, err_under, txn_done}), 32'd0);
        end
        checkOutput("both_balance", 32'(balance), 32'(model_bal));
        dep_btn = 1'b0;
        wdr_btn = 1'b0;

        // Reset in the middle of a deposit.
        @(negedge clk);
        sw = 6'b000100;
        @(negedge clk);
        dep_btn = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_balance", 32'(balance), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_outputs", 32'({txn_done, err_bill, err_over, err_under}), 32'd0);
        dep_btn = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_txn", 32'(txn_done), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        model_bal = 0;
        applyStimulus(1'b0, 6'b100000, 1'b0);

        // A button held for 50 cycles is one request.
        model_outcome(1'b0, 6'b000001, model_bal, kind, exp_bal, commits);
        @(negedge clk);
        sw = 6'b000001;
        dep_btn = 1'b1;
        count = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (txn_done) count++;
            if (i == 49) dep_btn = 1'b0;
        end
        checkOutput("held_txn_count", 32'(count), 32'(commits));
        checkOutput("held_balance", 32'(balance), 32'(exp_bal));
        model_bal = exp_bal;

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3) != 0) s = 6'(1 << $urandom_range(5));
            else                        s = 6'($urandom);
            applyStimulus(1'($urandom_range(1)), s, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
